bsg_mem_1rw_sync_mask_write_byte_arb2: RTL and testbench

//  Shares one single-port synchronous byte-masked RAM (bsg_mem_1rw_sync_mask_write_byte) between two requesters.

---
 rtl/bsg_mem_1rw_sync_mask_write_byte_arb2.sv | 128 ++++++++++++
 tb/tb_bsg_mem_1rw_sync_mask_write_byte_arb2.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bsg_mem_1rw_sync_mask_write_byte_arb2.sv
// bsg_mem_1rw_sync_mask_write_byte_arb2
//   Shares one single-port synchronous byte-masked RAM between two requesters.
//   Round-robin grant of at most one access per cycle. Each requester has a
//   one-entry read response slot with a valid/yumi handshake.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   v_i/w_i/addr_i/data_i/w_mask_i   per-requester request (held until ready_o)
//   ready_o                 per-requester grant (one-hot or zero, combinational)
//   v_o/data_o/yumi_i       per-requester read response
//   mem_*_o                 drive to the RAM port
//   mem_data_i              RAM read data, valid the cycle after a read

// Per-requester response slot. A read's data appears straight from the RAM
// in the cycle after the grant (PEND); if not consumed it is parked in a
// register (FULL) until yumi.
module bsg_mem_1rw_sync_mask_write_byte_arb2_slot #(
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rd_gnt_i,
  input  logic                    yumi_i,
  input  logic [data_width_p-1:0] mem_data_i,
  output logic                    v_o,
  output logic [data_width_p-1:0] data_o,
  output logic                    free_o
);
  typedef enum logic [1:0] {EMPTY, PEND, FULL} slot_state_e;

  slot_state_e state_r, state_n;
  logic [data_width_p-1:0] data_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= EMPTY;
    else         state_r <= state_n;
    // RAM output is only guaranteed in the PEND cycle, so grab it then.
    if (state_r == PEND) data_r <= mem_data_i;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      EMPTY:     if (rd_gnt_i) state_n = PEND;
      PEND, FULL: begin
        if (yumi_i)              state_n = rd_gnt_i ? PEND : EMPTY;
        else if (state_r == PEND) state_n = FULL;
      end
      default:   state_n = EMPTY;
    endcase
  end

  assign v_o    = (state_r != EMPTY);
  assign data_o = (state_r == PEND) ? mem_data_i : data_r;
  // Slot can accept a new read if empty now or being drained this cycle.
  assign free_o = (state_r == EMPTY) | (v_o & yumi_i);
endmodule

module bsg_mem_1rw_sync_mask_write_byte_arb2 #(
  parameter int els_p               = 16,
  parameter int data_width_p        = 32,
  parameter int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1,
  parameter int write_mask_width_lp = data_width_p >> 3
) (
  input  logic                                      clk_i,
  input  logic                                      reset_i,
  input  logic [1:0]                                v_i,
  input  logic [1:0]                                w_i,
  input  logic [1:0][addr_width_lp-1:0]             addr_i,
  input  logic [1:0][data_width_p-1:0]              data_i,
  input  logic [1:0][write_mask_width_lp-1:0]       w_mask_i,
  output logic [1:0]                                ready_o,
  output logic [1:0]                                v_o,
  output logic [1:0][data_width_p-1:0]              data_o,
  input  logic [1:0]                                yumi_i,
  output logic                                      mem_v_o,
  output logic                                      mem_w_o,
  output logic [addr_width_lp-1:0]                  mem_addr_o,
  output logic [data_width_p-1:0]                   mem_data_o,
  output logic [write_mask_width_lp-1:0]            mem_w_mask_o,
  input  logic [data_width_p-1:0]                   mem_data_i
);
  localparam int num_lanes_lp = 2;

  logic [num_lanes_lp-1:0] slot_free, elig;
  logic                    last_r;   // index of most recent grant
  logic                    gnt_idx;

  genvar r;
  generate
    for (r = 0; r < num_lanes_lp; r++) begin : lane
      assign elig[r] = v_i[r] & (w_i[r] | slot_free[r]) & ~reset_i;

      bsg_mem_1rw_sync_mask_write_byte_arb2_slot #(.data_width_p(data_width_p)) slot (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .rd_gnt_i   (ready_o[r] & ~w_i[r]),
        .yumi_i     (yumi_i[r]),
        .mem_data_i (mem_data_i),
        .v_o        (v_o[r]),
        .data_o     (data_o[r]),
        .free_o     (slot_free[r])
      );
    end
  endgenerate

  // On contention favour whoever was not granted last.
  always_comb begin
    ready_o = elig;
    if (&elig) ready_o = last_r ? 2'b01 : 2'b10;
  end

  assign gnt_idx = ready_o[1];

  // last_r=1 out of reset so requester 0 wins the first contention.
  always_ff @(posedge clk_i) begin
    if (reset_i)       last_r <= 1'b1;
    else if (|ready_o) last_r <= gnt_idx;
  end

  always_comb begin
    mem_v_o      = |ready_o;
    mem_w_o      = mem_v_o & w_i[gnt_idx];
    mem_addr_o   = mem_v_o ? addr_i[gnt_idx] : '0;
    mem_data_o   = mem_w_o ? data_i[gnt_idx] : '0;
    mem_w_mask_o = mem_w_o ? w_mask_i[gnt_idx] : '0;
  end
endmodule

// File: tb/tb_bsg_mem_1rw_sync_mask_write_byte_arb2.sv
module tb_bsg_mem_1rw_sync_mask_write_byte_arb2;
  localparam int ELS = 16;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int MW  = 4;

  logic                clk = 1'b0;
  logic                reset_i = 1'b1;
  logic [1:0]          v_i = '0, w_i = '0, yumi_i = '0;
  logic [1:0][AW-1:0]  addr_i = '0;
  logic [1:0][DW-1:0]  data_i = '0;
  logic [1:0][MW-1:0]  w_mask_i = '0;
  logic [1:0]          ready_o, v_o;
  logic [1:0][DW-1:0]  data_o;
  logic                mem_v_o, mem_w_o;
  logic [AW-1:0]       mem_addr_o;
  logic [DW-1:0]       mem_data_o, mem_data_i;
  logic [MW-1:0]       mem_w_mask_o;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_mask_write_byte_arb2 #(.els_p(ELS), .data_width_p(DW)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .w_i(w_i), .addr_i(addr_i),
    .data_i(data_i), .w_mask_i(w_mask_i), .ready_o(ready_o), .v_o(v_o),
    .data_o(data_o), .yumi_i(yumi_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_w_mask_o(mem_w_mask_o),
    .mem_data_i(mem_data_i)
  );

  // RAM stub on the DUT's memory port; cleared on reset so the model can mirror it.
  logic [DW-1:0] ram [ELS];
  always @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < ELS; i++) ram[i] <= '0;
    end else if (mem_v_o) begin
      if (mem_w_o) begin
        for (int b = 0; b < MW; b++)
          if (mem_w_mask_o[b]) ram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
      end else begin
        mem_data_i <= ram[mem_addr_o];
      end
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model: word memory, per-requester outstanding response, last grant.
  logic [DW-1:0] mmem [ELS];
  bit            resp_v [2];
  logic [DW-1:0] resp_d [2];
  bit            last_g;
  bit            rq_v [2], rq_w [2], yum [2], el [2];
  logic [AW-1:0] rq_a [2];
  logic [DW-1:0] rq_d [2];
  logic [MW-1:0] rq_m [2];

  initial begin
    int g, p;
    bit rst;
    logic [1:0] exp_rdy;
    for (int i = 0; i < ELS; i++) mmem[i] = '0;
    for (int r = 0; r < 2; r++) begin resp_v[r] = 0; rq_v[r] = 0; end
    last_g = 1;

    for (int cyc = 0; cyc < 2400; cyc++) begin
      @(negedge clk);
      rst = (cyc < 2) || (cyc == 900) || (cyc == 1500);
      // Phases: always consume, rarely consume, mostly consume.
      p = (cyc < 600) ? 100 : (cyc < 1200) ? 25 : 65;

      for (int r = 0; r < 2; r++) begin
        chk($sformatf("v_o[%0d]", r), v_o[r], resp_v[r]);
        if (resp_v[r]) chk($sformatf("data_o[%0d]", r), data_o[r], resp_d[r]);
        yum[r] = resp_v[r] && ($urandom_range(0, 99) < p);
        if (!rq_v[r] && $urandom_range(0, 99) < 70) begin
          rq_v[r] = 1;
          rq_w[r] = ($urandom_range(0, 99) < 40);
          rq_a[r] = AW'($urandom_range(0, 7));
          rq_d[r] = $urandom;
          rq_m[r] = MW'($urandom_range(0, 15));
        end
        v_i[r] = rq_v[r]; w_i[r] = rq_w[r]; addr_i[r] = rq_a[r];
        data_i[r] = rq_d[r]; w_mask_i[r] = rq_m[r]; yumi_i[r] = yum[r];
      end
      reset_i = rst;
      #1;

      for (int r = 0; r < 2; r++) el[r] = rq_v[r] && (rq_w[r] || !resp_v[r] || yum[r]);
      g = -1;
      if (!rst) begin
        if (el[0] && el[1]) g = last_g ? 0 : 1;
        else if (el[0])     g = 0;
        else if (el[1])     g = 1;
      end
      exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      chk("ready_o", ready_o, exp_rdy);
      chk("mem_v_o", mem_v_o, g >= 0);
      if (g >= 0) begin
        chk("mem_w_o",    mem_w_o,    rq_w[g]);
        chk("mem_addr_o", mem_addr_o, rq_a[g]);
        chk("mem_data_o", mem_data_o, rq_w[g] ? rq_d[g] : '0);
        chk("mem_mask_o", mem_w_mask_o, rq_w[g] ? rq_m[g] : '0);
      end else begin
        chk("mem_idle", {mem_w_o, mem_addr_o, mem_data_o, mem_w_mask_o}, '0);
      end

      @(posedge clk);
      if (rst) begin
        for (int r = 0; r < 2; r++) resp_v[r] = 0;
        for (int i = 0; i < ELS; i++) mmem[i] = '0;
        last_g = 1;
      end else begin
        for (int r = 0; r < 2; r++) if (yum[r]) resp_v[r] = 0;
        if (g >= 0) begin
          if (rq_w[g]) begin
            for (int b = 0; b < MW; b++)
              if (rq_m[g][b]) mmem[rq_a[g]][8*b +: 8] = rq_d[g][8*b +: 8];
          end else begin
            resp_v[g] = 1;
            resp_d[g] = mmem[rq_a[g]];
          end
          last_g = g[0];
          rq_v[g] = 0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
